// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared timing record, standard modes and config validity check
// for the programmable raster generator.
package vga_timing_pkg;

    localparam int VGA_CW = 12;
    localparam int AXIS_MAX = 2 ** VGA_CW - 1;

    typedef struct packed {
        logic [VGA_CW-1:0] act;
        logic [VGA_CW-1:0] fp;
        logic [VGA_CW-1:0] s;
        logic [VGA_CW-1:0] bp;
        logic              pol;
    } axis_t;

    typedef struct packed {
        axis_t h;
        axis_t v;
    } timing_t;

    function automatic axis_t mk_axis(int act, int fp, int s, int bp, int pol);
        return '{act: VGA_CW'(act), fp: VGA_CW'(fp), s: VGA_CW'(s), bp: VGA_CW'(bp), pol: 1'(pol)};
    endfunction

    localparam timing_t MODE_640X480 = '{h: mk_axis(640, 16, 96, 48, 0), v: mk_axis(480, 10, 2, 33, 0)};
    localparam timing_t MODE_800X600 = '{h: mk_axis(800, 40, 128, 88, 1), v: mk_axis(600, 1, 4, 23, 1)};

    // The total is summed two bits wider so an overflowing mode cannot alias to a legal one.
    function automatic logic axis_ok(axis_t a);
        logic [VGA_CW+1:0] sum;
        sum = (VGA_CW+2)'(a.act) + (VGA_CW+2)'(a.fp) + (VGA_CW+2)'(a.s) + (VGA_CW+2)'(a.bp);
        return (|a.act) && (|a.fp) && (|a.s) && (|a.bp) && (sum <= (VGA_CW+2)'(AXIS_MAX));
    endfunction

    function automatic logic timing_ok(timing_t t);
        return axis_ok(t.h) && axis_ok(t.v);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis; holds the active timing as precomputed
// thresholds so the per-pixel compares need no adders.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter axis_t DEF = '0
) (
    input  logic              pixel_clock,
    input  logic              reset,
    input  logic              tick,
    input  logic              clear,
    input  logic              load,
    input  axis_t             timing,
    output logic [VGA_CW-1:0] count,
    output logic              wrap,
    output logic              in_sync,
    output logic              in_active,
    output logic              pol
);

    logic [VGA_CW-1:0] act, sync_start, sync_end, last;

    always_ff @(posedge pixel_clock or posedge reset)
        if (reset) begin
            act        <= DEF.act;
            sync_start <= DEF.act + DEF.fp;
            sync_end   <= DEF.act + DEF.fp + DEF.s;
            last       <= DEF.act + DEF.fp + DEF.s + DEF.bp - VGA_CW'(1);
            pol        <= DEF.pol;
        end else if (load) begin
            act        <= timing.act;
            sync_start <= timing.act + timing.fp;
            sync_end   <= timing.act + timing.fp + timing.s;
            last       <= timing.act + timing.fp + timing.s + timing.bp - VGA_CW'(1);
            pol        <= timing.pol;
        end

    always_ff @(posedge pixel_clock or posedge reset)
        if (reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (tick)
            count <= wrap ? '0 : count + VGA_CW'(1);

    assign wrap      = count == last;
    assign in_sync   = count >= sync_start && count < sync_end;
    assign in_active = count < act;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: runtime-programmable VGA/DVI raster timing generator; new
// timing is staged in a pending slot and swapped in only at a frame boundary.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CW     = VGA_CW,
    parameter int D_HACT = 640,
    parameter int D_HFP  = 16,
    parameter int D_HS   = 96,
    parameter int D_HBP  = 48,
    parameter int D_VACT = 480,
    parameter int D_VFP  = 10,
    parameter int D_VS   = 2,
    parameter int D_VBP  = 33,
    parameter int D_HPOL = 0,
    parameter int D_VPOL = 0
) (
    input  logic          pixel_clock,
    input  logic          reset,
    input  logic          en,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_h_act,
    input  logic [CW-1:0] cfg_h_fp,
    input  logic [CW-1:0] cfg_h_s,
    input  logic [CW-1:0] cfg_h_bp,
    input  logic [CW-1:0] cfg_v_act,
    input  logic [CW-1:0] cfg_v_fp,
    input  logic [CW-1:0] cfg_v_s,
    input  logic [CW-1:0] cfg_v_bp,
    input  logic          cfg_h_pol,
    input  logic          cfg_v_pol,
    output logic          cfg_err,
    output logic          h_sync,
    output logic          v_sync,
    output logic          disp_enable,
    output logic [CW-1:0] column,
    output logic [CW-1:0] row,
    output logic          line_start,
    output logic          frame_start
);

    localparam timing_t DEF = '{h: mk_axis(D_HACT, D_HFP, D_HS, D_HBP, D_HPOL),
                                v: mk_axis(D_VACT, D_VFP, D_VS, D_VBP, D_VPOL)};

    timing_t           cfg, pend;
    logic              pend_v, xfer, cfg_ok, frame_end, apply;
    logic [VGA_CW-1:0] hc, vc;
    logic              h_wrap, h_in_sync, h_in_act, h_pol;
    logic              v_wrap, v_in_sync, v_in_act, v_pol;

    assign cfg = '{h: '{act: cfg_h_act, fp: cfg_h_fp, s: cfg_h_s, bp: cfg_h_bp, pol: cfg_h_pol},
                   v: '{act: cfg_v_act, fp: cfg_v_fp, s: cfg_v_s, bp: cfg_v_bp, pol: cfg_v_pol}};

    assign cfg_ready = !pend_v;
    assign xfer      = cfg_valid && cfg_ready;
    assign cfg_ok    = timing_ok(cfg);
    assign frame_end = en && h_wrap && v_wrap;
    // While stopped the counters sit at 0, so a pending mode can land at once.
    assign apply     = pend_v && (frame_end || !en);

    always_ff @(posedge pixel_clock or posedge reset)
        if (reset) begin
            pend   <= '0;
            pend_v <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= xfer && !cfg_ok;
            if (xfer && cfg_ok) begin
                pend   <= cfg;
                pend_v <= 1'b1;
            end else if (apply)
                pend_v <= 1'b0;
        end

    vga_axis_counter #(.DEF(DEF.h)) u_h (
        .pixel_clock(pixel_clock),
        .reset(reset),
        .tick(en),
        .clear(!en),
        .load(apply),
        .timing(pend.h),
        .count(hc),
        .wrap(h_wrap),
        .in_sync(h_in_sync),
        .in_active(h_in_act),
        .pol(h_pol)
    );

    vga_axis_counter #(.DEF(DEF.v)) u_v (
        .pixel_clock(pixel_clock),
        .reset(reset),
        .tick(en && h_wrap),
        .clear(!en),
        .load(apply),
        .timing(pend.v),
        .count(vc),
        .wrap(v_wrap),
        .in_sync(v_in_sync),
        .in_active(v_in_act),
        .pol(v_pol)
    );

    always_ff @(posedge pixel_clock or posedge reset)
        if (reset) begin
            h_sync      <= !DEF.h.pol;
            v_sync      <= !DEF.v.pol;
            disp_enable <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            column      <= '0;
            row         <= '0;
        end else begin
            h_sync      <= (en && h_in_sync) ? h_pol : !h_pol;
            v_sync      <= (en && v_in_sync) ? v_pol : !v_pol;
            disp_enable <= en && h_in_act && v_in_act;
            line_start  <= en && hc == '0 && v_in_act;
            frame_start <= en && hc == '0 && vc == '0;
            column      <= hc;
            row         <= vc;
        end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for the raster generator, with a small
// raster model and explicit checks of the config handshake and mode switches.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    localparam int CW = 12;
    localparam timing_t T_DEF   = '{h: mk_axis(640, 16, 96, 48, 0), v: mk_axis(480, 10, 2, 33, 0)};
    localparam timing_t T_A     = '{h: mk_axis(8, 2, 3, 2, 0), v: mk_axis(4, 1, 2, 1, 0)};
    localparam timing_t T_B     = '{h: mk_axis(10, 1, 2, 3, 1), v: mk_axis(3, 2, 1, 2, 1)};
    localparam timing_t T_C     = '{h: mk_axis(5, 1, 1, 1, 1), v: mk_axis(2, 1, 1, 1, 0)};
    localparam timing_t BAD_S   = '{h: mk_axis(640, 16, 0, 48, 0), v: mk_axis(480, 10, 2, 33, 0)};
    localparam timing_t BAD_BIG = '{h: mk_axis(4000, 50, 50, 50, 0), v: mk_axis(480, 10, 2, 33, 0)};

    logic pixel_clock = 1'b0;
    logic reset, en, cfg_valid, cfg_ready, cfg_err;
    logic h_sync, v_sync, disp_enable, line_start, frame_start;
    logic [CW-1:0] column, row;
    timing_t cfg_t;

    int checks = 0, failures = 0;
    timing_t mt, mpend;
    logic mpv, men, applied;
    int mh, mv, mis, fs_cnt, idle_n, idle_bad;

    always #5 pixel_clock = ~pixel_clock;

    vga_timing_gen dut (
        .pixel_clock(pixel_clock),
        .reset(reset),
        .en(en),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_h_act(cfg_t.h.act),
        .cfg_h_fp(cfg_t.h.fp),
        .cfg_h_s(cfg_t.h.s),
        .cfg_h_bp(cfg_t.h.bp),
        .cfg_v_act(cfg_t.v.act),
        .cfg_v_fp(cfg_t.v.fp),
        .cfg_v_s(cfg_t.v.s),
        .cfg_v_bp(cfg_t.v.bp),
        .cfg_h_pol(cfg_t.h.pol),
        .cfg_v_pol(cfg_t.v.pol),
        .cfg_err(cfg_err),
        .h_sync(h_sync),
        .v_sync(v_sync),
        .disp_enable(disp_enable),
        .column(column),
        .row(row),
        .line_start(line_start),
        .frame_start(frame_start)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int tot(axis_t a);
        return int'(a.act) + int'(a.fp) + int'(a.s) + int'(a.bp);
    endfunction

    // Expected {h_sync, v_sync, disp_enable, line_start, frame_start, column, row} for one pixel.
    function automatic logic [28:0] expv(int h, int v, timing_t t, logic e);
        int hss, hse, vss, vse;
        logic hs, vs;
        hss = int'(t.h.act) + int'(t.h.fp);
        hse = hss + int'(t.h.s);
        vss = int'(t.v.act) + int'(t.v.fp);
        vse = vss + int'(t.v.s);
        hs = (e && h >= hss && h < hse) ? t.h.pol : !t.h.pol;
        vs = (e && v >= vss && v < vse) ? t.v.pol : !t.v.pol;
        return {hs, vs, e && h < int'(t.h.act) && v < int'(t.v.act),
                e && h == 0 && v < int'(t.v.act), e && h == 0 && v == 0, 12'(h), 12'(v)};
    endfunction

    task automatic take_pending();
        if (mpv) begin
            mt = mpend;
            mpv = 1'b0;
            applied = 1'b1;
        end
    endtask

    task automatic step();
        applied = 1'b0;
        if (!men) begin
            mh = 0;
            mv = 0;
            take_pending();
        end else if (mh == tot(mt.h) - 1) begin
            mh = 0;
            if (mv == tot(mt.v) - 1) begin
                mv = 0;
                take_pending();
            end else
                mv++;
        end else
            mh++;
    endtask

    task automatic tick();
        @(negedge pixel_clock);
        if ({h_sync, v_sync, disp_enable, line_start, frame_start, column, row} !== expv(mh, mv, mt, men))
            mis++;
        if (frame_start) fs_cnt++;
        if (!men) begin
            idle_n++;
            if (disp_enable || line_start || frame_start || !h_sync || !v_sync) idle_bad++;
        end
        step();
    endtask

    task automatic scan(input string tag, input int n);
        for (int i = 0; i < n; i++) tick();
        check(tag, mis, 0);
        mis = 0;
    endtask

    task automatic set_en(input logic b);
        en = b;
        men = b;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_h_sync"}, h_sync, 1);
        check({tag, "_v_sync"}, v_sync, 1);
        check({tag, "_disp_enable"}, disp_enable, 0);
        check({tag, "_line_start"}, line_start, 0);
        check({tag, "_frame_start"}, frame_start, 0);
        check({tag, "_column"}, column, 0);
        check({tag, "_row"}, row, 0);
        check({tag, "_cfg_err"}, cfg_err, 0);
        check({tag, "_cfg_ready"}, cfg_ready, 1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int hs_n, hs_first, hs_last, ls_n, ls2, fs_n, vs_low, de_n, row800;
        int waited, low_err, hs1, vs1, fs0;
        reset = 1'b1;
        cfg_valid = 1'b0;
        cfg_t = T_DEF;
        set_en(1'b1);
        mt = T_DEF;
        mh = 0;
        mv = 0;
        mpv = 1'b0;
        mis = 0;
        fs_cnt = 0;
        idle_n = 0;
        idle_bad = 0;
        @(negedge pixel_clock);
        check_reset_outputs("reset");
        reset = 1'b0;

        // Default 640x480 raster over the first two lines.
        hs_n = 0; hs_first = -1; hs_last = -1; ls_n = 0; ls2 = -1; fs_n = 0; vs_low = 0; de_n = 0; row800 = -1;
        for (int i = 0; i < 1600; i++) begin
            tick();
            if (i == 0) begin
                check("first_frame_start", frame_start, 1);
                check("first_column", column, 0);
            end
            if (i < 800 && !h_sync) begin
                hs_n++;
                if (hs_first < 0) hs_first = int'(column);
                hs_last = int'(column);
            end
            if (line_start) begin
                ls_n++;
                if (ls_n == 2) ls2 = i;
            end
            if (frame_start) fs_n++;
            if (!v_sync) vs_low++;
            if (disp_enable) de_n++;
            if (i == 800) row800 = int'(row);
        end
        check("def_hsync_low_cycles", hs_n, 96);
        check("def_hsync_first_col", hs_first, 656);
        check("def_hsync_last_col", hs_last, 751);
        check("def_line_starts", ls_n, 2);
        check("def_line_period", ls2, 800);
        check("def_row_at_800", row800, 1);
        check("def_frame_starts", fs_n, 1);
        check("def_vsync_low", vs_low, 0);
        check("def_de_cycles", de_n, 1280);
        scan("def_raster", 0);

        // Rejected configs: zero sync width, then an oversized total.
        cfg_t = BAD_S;
        cfg_valid = 1'b1;
        check("bad_s_ready_before", cfg_ready, 1);
        tick();
        cfg_valid = 1'b0;
        check("bad_s_err_pulse", cfg_err, 1);
        check("bad_s_ready_after", cfg_ready, 1);
        tick();
        check("bad_s_err_once", cfg_err, 0);
        cfg_t = BAD_BIG;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        check("bad_big_err_pulse", cfg_err, 1);
        check("bad_big_ready", cfg_ready, 1);
        scan("def_after_bad", 300);

        // Stop the raster for 50 cycles and load mode A while stopped.
        set_en(1'b0);
        scan("en_low_pre", 3);
        cfg_t = T_A;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        mpend = T_A;
        mpv = 1'b1;
        check("a_ready_low", cfg_ready, 0);
        tick();
        check("a_ready_back", cfg_ready, 1);
        scan("en_low_rest", 45);
        check("en_low_cycles", idle_n, 50);
        check("en_low_inactive", idle_bad, 0);

        fs0 = fs_cnt;
        set_en(1'b1);
        tick();
        check("en_return_frame_start", frame_start, 1);
        check("en_return_column", column, 0);
        check("en_return_row", row, 0);
        scan("mode_a_frames", 239);
        check("mode_a_fs_per_240", fs_cnt - fs0, 2);

        // Mid-frame load of B, with C offered while B is still pending.
        scan("a_mid", 37);
        cfg_t = T_B;
        cfg_valid = 1'b1;
        tick();
        mpend = T_B;
        mpv = 1'b1;
        cfg_t = T_C;
        check("b_ready_low", cfg_ready, 0);
        waited = 0;
        low_err = 0;
        while (!applied && waited < 300) begin
            tick();
            waited++;
            if (!applied && cfg_ready) low_err++;
        end
        check("b_apply_wait", waited, 82);
        check("b_ready_held_low", low_err, 0);
        check("b_ready_rise", cfg_ready, 1);
        tick();
        cfg_valid = 1'b0;
        mpend = T_C;
        mpv = 1'b1;
        check("c_ready_low", cfg_ready, 0);
        hs1 = 0;
        vs1 = 0;
        for (int i = 0; i < 127; i++) begin
            tick();
            if (h_sync) hs1++;
            if (v_sync) vs1++;
        end
        check("b_hsync_high", hs1, 16);
        check("b_vsync_high", vs1, 16);
        scan("mode_b_frame", 0);
        check("c_ready_after_apply", cfg_ready, 1);
        scan("mode_c_frames", 80);

        // Transfer on the last pixel of a frame: one more C frame, then A.
        scan("c_to_last", 39);
        cfg_t = T_A;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        mpend = T_A;
        mpv = 1'b1;
        check("last_ready_low", cfg_ready, 0);
        fs0 = fs_cnt;
        scan("late_c_frame", 40);
        check("late_c_frame_starts", fs_cnt - fs0, 1);
        check("late_ready_rise", cfg_ready, 1);
        scan("late_a_frame", 120);

        // Asynchronous reset mid-frame with a config pending.
        scan("a_pre_reset", 35);
        check("pre_reset_column", column, 4);
        cfg_t = T_B;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        check("pre_reset_at_col5", column, 5);
        #2 reset = 1'b1;
        #1 check_reset_outputs("mid_reset");
        @(negedge pixel_clock);
        reset = 1'b0;
        mt = T_DEF;
        mpv = 1'b0;
        mh = 0;
        mv = 0;
        mis = 0;
        tick();
        check("post_reset_frame_start", frame_start, 1);
        scan("post_reset_default", 1700);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Runtime-programmable VGA/DVI raster timing generator. It supersedes the fixed-parameter controller.
- Produces sync pulses, display enable, pixel coordinates, and line-start and frame-start strobes, all from one pixel clock.
- Timing is reloadable through a valid/ready config port. New timing takes effect only on a frame boundary, so mode switches do not tear the raster.
- It sits between the pixel clock domain and the pixel source / output encoder.

Parameters:
- CW, 12, width of the counters, coordinates and config fields.
- D_HACT, 640, reset-default horizontal active pixels.
- D_HFP, 16, reset-default horizontal front porch.
- D_HS, 96, reset-default horizontal sync width.
- D_HBP, 48, reset-default horizontal back porch.
- D_VACT, 480, reset-default vertical active lines.
- D_VFP, 10, reset-default vertical front porch.
- D_VS, 2, reset-default vertical sync width.
- D_VBP, 33, reset-default vertical back porch.
- D_HPOL, 0, reset-default horizontal sync polarity (1 = active-high).
- D_VPOL, 0, reset-default vertical sync polarity (1 = active-high).

Ports:
- pixel_clock  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  run enable
- cfg_valid  in  1  config offer
- cfg_ready  out  1  config slot free
- cfg_h_act, cfg_h_fp, cfg_h_s, cfg_h_bp  in  CW each  horizontal timing fields
- cfg_v_act, cfg_v_fp, cfg_v_s, cfg_v_bp  in  CW each  vertical timing fields
- cfg_h_pol, cfg_v_pol  in  1 each  sync polarities
- cfg_err  out  1  one-cycle pulse, config rejected
- h_sync, v_sync  out  1 each  sync outputs
- disp_enable  out  1  pixel is in the active area
- column, row  out  CW each  raw horizontal/vertical counter values
- line_start  out  1  first pixel of an active line
- frame_start  out  1  first pixel of a frame

Behaviour:
- Raster order per line: active, front porch, sync, back porch. Totals are HT = act+fp+s+bp and VT likewise.
- Counters:
  - hc runs 0..HT-1. On hc == HT-1 it wraps to 0 and vc increments.
  - vc runs 0..VT-1. On hc == HT-1 && vc == VT-1, both counters wrap to 0.
- Output latency: all outputs are registered with 1-cycle latency. In cycle n+1 they reflect (hc, vc) of cycle n, so column/row, syncs, disp_enable and strobes are mutually aligned.
- h_sync = HPOL when act+fp <= hc < act+fp+s, else !HPOL.
- v_sync = VPOL when act+fp <= vc < act+fp+s (vertical fields), else !VPOL.
- disp_enable = (hc < h_act) && (vc < v_act).
- line_start = (hc == 0) && (vc < v_act).
- frame_start = (hc == 0) && (vc == 0).
- Reset:
  - hc = vc = 0.
  - Active timing registers load the D_* defaults; the pending slot is empty.
  - Outputs: h_sync = !D_HPOL, v_sync = !D_VPOL; disp_enable, line_start, frame_start, column, row and cfg_err all 0; cfg_ready = 1.
- Config handshake:
  - A transfer occurs when cfg_valid && cfg_ready.
  - Validity check on the transfer: every field is nonzero, and HT and VT (computed in CW+2 bits) are each <= 2^CW - 1.
  - Valid config: captured into the pending slot; cfg_ready drops on the next cycle.
  - Invalid config: not captured; cfg_err pulses one cycle later; cfg_ready stays 1.
- Apply: a pending config replaces the active timing in the cycle where both counters wrap (end of frame). The new frame starts at 0 with the new timing. The pending slot clears and cfg_ready rises on the next cycle.
- Transfer in the same cycle as end of frame: the config is captured, not applied; it is applied at the following frame end.
- en = 0:
  - Counters are held at 0; outputs are inactive (syncs at their non-asserted level, disp_enable and strobes 0).
  - Any pending config is applied on the next clock; the handshake still operates.
  - When en returns to 1, the first output cycle shows hc = 0, vc = 0 with frame_start = 1.
- Reset mid-frame or mid-apply: everything returns to the reset state and the pending config is discarded.
- Arithmetic: counters are unsigned CW bits. Comparison thresholds are precomputed into registers whenever the active timing loads, so no adder sits on the compare path.

Decomposition:
- Package vga_timing_pkg:
  - timing record typedef (act, fp, s, bp, pol per axis);
  - 640x480@60 and 800x600@60 default constants;
  - a validity-check function.
- Sub-module vga_axis_counter, instantiated twice (horizontal and vertical):
  - inputs: tick, active timing;
  - outputs: count, wrap, in_sync, in_active.

Test Plan:
- Reset, en = 1, defaults: h_sync low for exactly 96 cycles with column = 656..751; line period 800 cycles; frame period 420000 cycles; v_sync low on rows 490..491; frame_start once per frame.
- Mid-frame load of 800x600 (h 800/40/128/88, v 600/1/4/23, pol 1/1): current frame completes at 800x525; next frame has HT = 1056, VT = 628 and active-high syncs; cfg_ready low from the transfer until one cycle after the apply.
- cfg_h_s = 0 offered → cfg_err pulses once one cycle later; timing unchanged; cfg_ready stays 1.
- Second cfg_valid while a config is pending → no transfer (cfg_ready = 0); accepted after the apply; applied at the subsequent frame end.
- Config transfer coinciding with the last pixel of a frame → old timing runs one more full frame, then the new timing takes over.
- reset asserted at column 300, row 100 → outputs at reset values immediately; after release, frame_start seen on the first enabled cycle. Separately, en low for 50 cycles → disp_enable 0 and syncs inactive throughout.
